// File: rtl/adc_decimator_pkg.sv
// Shared definitions for the ADC decimator front end: FSM encoding, default
// decimation depth and the fractional-bit convention used downstream.
package adc_decimator_pkg;

  localparam int unsigned DEFAULT_MAX_DECIM_LOG2 = 4;

  // Output carries MAX_DECIM_LOG2 fractional bits; downstream Q scaling relies on this.
  localparam int unsigned DEFAULT_FRAC_BITS = DEFAULT_MAX_DECIM_LOG2;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } dec_state_t;

  function automatic int unsigned clamp_decim(input int unsigned req,
                                              input int unsigned max_log2);
    return (req > max_log2) ? max_log2 : req;
  endfunction

endpackage

// File: rtl/adc_sample_sign.sv
// Converts a raw ADC code to two's complement and flags full-scale (clipping) codes.
module adc_sample_sign #(
  parameter int unsigned X_WIDTH = 12
) (
  input  logic                      offset_binary,
  input  logic [X_WIDTH-1:0]        raw,
  output logic signed [X_WIDTH-1:0] sample_c,
  output logic                      clip_code_c
);

  localparam logic [X_WIDTH-1:0] MSB_MASK = {1'b1, {(X_WIDTH-1){1'b0}}};
  localparam logic [X_WIDTH-1:0] CODE_MIN = {1'b1, {(X_WIDTH-1){1'b0}}};
  localparam logic [X_WIDTH-1:0] CODE_MAX = {1'b0, {(X_WIDTH-1){1'b1}}};

  logic [X_WIDTH-1:0] code_c;

  // Offset-binary extremes map onto the two's-complement extremes after the MSB flip.
  always_comb begin
    code_c      = offset_binary ? (raw ^ MSB_MASK) : raw;
    sample_c    = code_c;
    clip_code_c = (code_c == CODE_MIN) || (code_c == CODE_MAX);
  end

endmodule

// File: rtl/adc_decimator.sv
// Boxcar decimator: averages 2^D ADC samples per frame and emits one
// sign-extended fixed-point result, with sticky clip detection.
module adc_decimator
  import adc_decimator_pkg::*;
#(
  parameter int unsigned X_WIDTH        = 12,
  parameter int unsigned PRECISION      = 24,
  parameter int unsigned MAX_DECIM_LOG2 = DEFAULT_MAX_DECIM_LOG2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 offset_binary,
  input  logic [3:0]           decim_log2,
  input  logic                 in_valid,
  input  logic [X_WIDTH-1:0]   in_sample,
  output logic                 out_valid,
  output logic [PRECISION-1:0] out_sample,
  output logic                 clip,
  input  logic                 clip_clr
);

  localparam int unsigned A_WIDTH = X_WIDTH + MAX_DECIM_LOG2;
  localparam int unsigned CNT_W   = (MAX_DECIM_LOG2 > 0) ? MAX_DECIM_LOG2 : 1;
  localparam int unsigned D_W     = (MAX_DECIM_LOG2 > 0) ? $clog2(MAX_DECIM_LOG2 + 1) : 1;

  if (PRECISION < A_WIDTH) begin : g_precision_check
    $error("adc_decimator: PRECISION must be >= X_WIDTH + MAX_DECIM_LOG2");
  end

  dec_state_t state, state_next;

  logic signed [X_WIDTH-1:0]   sample_c;
  logic                        clip_code_c;
  logic signed [A_WIDTH-1:0]   acc;
  logic signed [A_WIDTH-1:0]   sum_c;
  logic signed [PRECISION-1:0] wide_c;
  logic [CNT_W-1:0]            count;
  logic [CNT_W-1:0]            last_count_c;
  logic [D_W-1:0]              d_active;
  logic [D_W-1:0]              d_req_c;
  logic [D_W-1:0]              shift_c;
  logic                        accept_c;
  logic                        frame_end_c;
  logic                        load_d_c;

  adc_sample_sign #(
    .X_WIDTH (X_WIDTH)
  ) u_sign (
    .offset_binary (offset_binary),
    .raw           (in_sample),
    .sample_c      (sample_c),
    .clip_code_c   (clip_code_c)
  );

  always_comb begin
    d_req_c      = D_W'(clamp_decim(32'(decim_log2), MAX_DECIM_LOG2));
    last_count_c = CNT_W'((1 << d_active) - 1);
    sum_c        = acc + A_WIDTH'(sample_c);
    wide_c       = PRECISION'(sum_c);
    shift_c      = D_W'(MAX_DECIM_LOG2) - d_active;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state plus datapath strobes; D is captured on entry and at each frame boundary.
  always_comb begin
    state_next  = state;
    accept_c    = 1'b0;
    load_d_c    = 1'b0;
    frame_end_c = 1'b0;
    case (state)
      IDLE: begin
        if (en) begin
          state_next = ACCUM;
          load_d_c   = 1'b1;
        end
      end
      ACCUM: begin
        if (!en) state_next = IDLE;
        else     accept_c   = in_valid;
      end
      default: state_next = IDLE;
    endcase
    frame_end_c = accept_c && (count == last_count_c);
    if (frame_end_c) load_d_c = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_sample <= '0;
      clip       <= 1'b0;
      acc        <= '0;
      count      <= '0;
      d_active   <= '0;
    end else begin
      out_valid <= frame_end_c;
      if (frame_end_c) out_sample <= wide_c <<< shift_c;
      if (load_d_c) d_active <= d_req_c;
      // Leaving ACCUM or closing a frame both restart accumulation from zero.
      if (state_next == IDLE || frame_end_c) begin
        acc   <= '0;
        count <= '0;
      end else if (accept_c) begin
        acc   <= sum_c;
        count <= count + CNT_W'(1);
      end
      if (accept_c && clip_code_c) clip <= 1'b1;
      else if (clip_clr)           clip <= 1'b0;
    end
  end

endmodule
